// File: rtl/synth_pkg.sv
// Shared types and constants for the ADSR voice channel.
// The LFSR constants are only referenced when ADSR_NOISE_WAVE_EN is defined.
package synth_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  typedef enum logic [1:0] {
    WAVE_SQUARE   = 2'b00,
    WAVE_TRIANGLE = 2'b01,
    WAVE_SAW      = 2'b10,
    WAVE_NOISE    = 2'b11
  } waveform_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate edge detection, per-state rate divider and level FSM.
// rst is active-low and is expected to be already release-synchronised by the parent.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int E = 8,
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gate,
  input  logic [R-1:0] attack_rate,
  input  logic [R-1:0] decay_rate,
  input  logic [R-1:0] release_rate,
  input  logic [E-1:0] sustain_level,
  output env_state_t   state,
  output logic [E-1:0] level
);

  localparam logic [E-1:0] LEVEL_MAX = '1;

  env_state_t   state_reg, state_next;
  logic [E-1:0] level_reg, level_next;
  logic [R-1:0] rate_cnt_reg, rate_cnt_next;
  logic [R-1:0] cur_rate;
  logic         gate_q_reg;
  logic         rise, fall, tick;

  assign rise = gate & ~gate_q_reg;
  assign fall = ~gate & gate_q_reg;
  assign tick = (rate_cnt_reg == cur_rate);

  always_comb begin
    cur_rate = '0;
    case (state_reg)
      ENV_ATTACK:  cur_rate = attack_rate;
      ENV_DECAY:   cur_rate = decay_rate;
      ENV_RELEASE: cur_rate = release_rate;
      default:     cur_rate = '0;
    endcase
  end

  // Bounds are tested before stepping, so the level saturates instead of wrapping
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    case (state_reg)
      ENV_IDLE: ;
      ENV_ATTACK: begin
        if (fall)                        state_next = ENV_RELEASE;
        else if (level_reg == LEVEL_MAX) state_next = ENV_DECAY;
        else if (tick)                   level_next = level_reg + E'(1);
      end
      ENV_DECAY: begin
        if (fall)                            state_next = ENV_RELEASE;
        else if (level_reg <= sustain_level) state_next = ENV_SUSTAIN;
        else if (tick)                       level_next = level_reg - E'(1);
      end
      ENV_SUSTAIN: begin
        if (fall) state_next = ENV_RELEASE;
        else      level_next = sustain_level;
      end
      ENV_RELEASE: begin
        if (level_reg == '0) state_next = ENV_IDLE;
        else if (tick)       level_next = level_reg - E'(1);
      end
      default: state_next = ENV_IDLE;
    endcase
    // A new note restarts the attack from wherever the level currently is
    if (rise) begin
      state_next = ENV_ATTACK;
      level_next = level_reg;
    end
  end

  always_comb begin
    rate_cnt_next = '0;
    if (rise || (state_next != state_reg))
      rate_cnt_next = '0;
    else if (state_reg inside {ENV_ATTACK, ENV_DECAY, ENV_RELEASE})
      rate_cnt_next = tick ? '0 : rate_cnt_reg + R'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ENV_IDLE;
      level_reg    <= '0;
      rate_cnt_reg <= '0;
      gate_q_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      level_reg    <= level_next;
      rate_cnt_reg <= rate_cnt_next;
      gate_q_reg   <= gate;
    end
  end

  assign state = state_reg;
  assign level = level_reg;

endmodule

// File: rtl/adsr_channel.sv
// One synthesiser voice: pitch divider, phase oscillator, waveform select and envelope mixing.
// Define ADSR_NOISE_WAVE_EN to make waveform 2'b11 an LFSR noise source; otherwise it plays square.
module adsr_channel
  import synth_pkg::*;
#(
  parameter int M = 6,
  parameter int N = 11,
  parameter int C = 12,
  parameter int E = 8,
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [C-1:0] pitch,
  input  logic [1:0]   waveform,
  input  logic         gate,
  input  logic [R-1:0] attack_rate,
  input  logic [R-1:0] decay_rate,
  input  logic [R-1:0] release_rate,
  input  logic [E-1:0] sustain_level,
  output logic [2:0]   env_state,
  output logic [N-1:0] out
);

  localparam int TRI_SHIFT = N - M + 1;
  localparam int SAW_SHIFT = N - M;

  // Reset asserts asynchronously but leaves on a clock edge
  logic rst_meta_reg, rst_sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end

  logic [C-1:0] pitch_cnt_reg;
  logic [M-1:0] period_reg;
  logic         step;

  assign step = (pitch_cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg) begin
      pitch_cnt_reg <= '0;
      period_reg    <= '0;
    end else begin
      pitch_cnt_reg <= step ? pitch : pitch_cnt_reg - C'(1);
      if (step) period_reg <= period_reg + M'(1);
    end
  end

`ifdef ADSR_NOISE_WAVE_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg)
      lfsr_reg <= LFSR_SEED;
    else if (step && (period_reg == '1))
      lfsr_reg <= lfsr_next(lfsr_reg);
  end
`endif

  env_state_t   env_state_w;
  logic [E-1:0] level;

  adsr_envelope #(
    .E(E),
    .R(R)
  ) u_envelope (
    .clk          (clk),
    .rst          (rst_sync_reg),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .release_rate (release_rate),
    .sustain_level(sustain_level),
    .state        (env_state_w),
    .level        (level)
  );

  assign env_state = env_state_w;

  logic [M-1:0] tri_dist;
  logic [N-1:0] tri_wave, saw_wave, square_wave, wave;

  always_comb begin
    // Distance from phase 0 around the cycle; peaks at half-period
    tri_dist    = period_reg[M-1] ? -period_reg : period_reg;
    tri_wave    = tri_dist[M-1] ? '1 : (N'(tri_dist) << TRI_SHIFT);
    saw_wave    = N'(period_reg) << SAW_SHIFT;
    square_wave = period_reg[M-1] ? '0 : '1;
    wave        = square_wave;
    case (waveform_t'(waveform))
      WAVE_SQUARE:   wave = square_wave;
      WAVE_TRIANGLE: wave = tri_wave;
      WAVE_SAW:      wave = saw_wave;
`ifdef ADSR_NOISE_WAVE_EN
      default:       wave = lfsr_reg[15 -: N];
`else
      default:       wave = square_wave;
`endif
    endcase
  end

  logic [N+E-1:0] product;

  assign product = (N+E)'(wave) * (N+E)'(level);

  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg) out <= '0;
    else               out <= N'(product >> E);
  end

endmodule

// File: doc/adsr_channel.md
ADSR_CHANNEL -- requirements
Module: adsr_channel

Interface
REQ-001 SHALL have parameter M, default 6, oscillator phase (period) width in bits.
REQ-002 SHALL have parameter N, default 11, output sample width in bits.
REQ-003 SHALL have parameter C, default 12, pitch divider width in bits.
REQ-004 SHALL have parameter E, default 8, envelope level width in bits.
REQ-005 SHALL have parameter R, default 8, envelope rate width in bits.
REQ-006 SHALL have port clk  input  1  sole clock; one clock domain.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port pitch  input  C  oscillator step divider reload value.
REQ-009 SHALL have port waveform  input  2  00 square, 01 triangle, 10 saw, 11 noise.
REQ-010 SHALL have port gate  input  1  note held while high.
REQ-011 SHALL have ports attack_rate, decay_rate, release_rate  input  R each  envelope step dividers.
REQ-012 SHALL have port sustain_level  input  E  sustain envelope level.
REQ-013 SHALL have port env_state  output  3  current envelope state encoding.
REQ-014 SHALL have port out  output  N  enveloped sample, registered.

Function
REQ-015 Pitch counter SHALL reload pitch at 0, else decrement; each reload emits one step pulse, so fout = clk/((pitch+1)*2^M).
REQ-016 pitch changes SHALL take effect only at next reload; pitch=0 steps every clk.
REQ-017 period SHALL increment by 1 per step pulse, wrapping 2^M-1 -> 0.
REQ-018 Square = all ones when period MSB=0, else 0; saw = period left-aligned to N bits; triangle = period rising then falling, full-scale at period 2^(M-1).
REQ-019 Noise = top N bits of 16-bit Galois LFSR (taps 16,14,13,11), advanced once per period wrap.
REQ-020 gate SHALL be registered (gate_q); rise = gate & ~gate_q, fall = ~gate & gate_q.
REQ-021 FSM states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; level E bits.
REQ-022 Envelope tick SHALL fire when rate counter reaches the current state's rate, then counter clears; rate 0 = tick every clk; counter clears on every state change.
REQ-023 ATTACK: level +1 per tick; at 2^E-1 -> DECAY.
REQ-024 DECAY: level -1 per tick; when level <= sustain_level -> SUSTAIN.
REQ-025 SUSTAIN: level SHALL equal sustain_level every cycle (live tracking).
REQ-026 gate fall in ATTACK/DECAY/SUSTAIN -> RELEASE from current level; RELEASE: level -1 per tick; at 0 -> IDLE.
REQ-027 gate rise in any state -> ATTACK from current level (no zeroing); rise wins over any simultaneous transition.
REQ-028 Level SHALL never wrap below 0 or above 2^E-1.
REQ-029 out SHALL register (wave * level) >> E, truncated to N bits, one clk latency from period/level.

Reset
REQ-030 rst low SHALL immediately force: period 0, pitch counter 0, rate counter 0, level 0, state IDLE, gate_q 0, LFSR 16'hACE1, out 0.
REQ-031 Release of rst SHALL be synchronised so state leaves reset on a clk edge; gate high at deassertion counts as rise.

Configuration
REQ-032 Macro ADSR_NOISE_WAVE_EN defined: waveform 11 selects LFSR noise, LFSR present.
REQ-033 Macro undefined: waveform 11 selects square; no LFSR logic synthesised.

Structure
REQ-034 Package synth_pkg SHALL hold env_state_t enum, waveform_t enum, LFSR_SEED and LFSR_TAPS constants.
REQ-035 Envelope FSM, rate counter and level SHALL be sub-module adsr_envelope; oscillator and mixing stay in adsr_channel.

Verification
REQ-036 Saw, pitch=0, gate high, attack_rate=0: period steps every clk; level 255 after 255 cycles post-rise, state DECAY next.
REQ-037 attack_rate=3: level +1 every 4 clks; ATTACK->DECAY 1020 clks after rise detect.
REQ-038 Square, decay_rate=0, sustain_level=128: SUSTAIN after 127 DECAY cycles; out high = 1023.
REQ-039 Gate drop at level 40, release_rate=1: level 0 after 80 clks, IDLE, out 0.
REQ-040 Gate re-rise in RELEASE at level 60: ATTACK resumes from 60, no step to 0.
REQ-041 rst low mid-SUSTAIN, no clk edge: out 0, env_state IDLE, period 0 immediately.
